// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style LCD bus: single status/data reads with optional busy polling.
// Optional poll limit with oTimeout is built only when LCD_READ_TIMEOUT_EN is defined.
module lcd_bus_reader #(
  parameter int SETUP_CYC  = 2,
  parameter int CLK_DIVIDE = 16,
  parameter int HOLD_CYC   = 2,
  parameter int MAX_POLLS  = 1024
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oTimeout,
  output logic       oBUS_READ,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_EN_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
    $error("SETUP_CYC must be 1..255");
  end
  if (CLK_DIVIDE < 1 || CLK_DIVIDE > 255) begin : g_bad_divide
    $error("CLK_DIVIDE must be 1..255");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
    $error("HOLD_CYC must be 1..255");
  end
  if (MAX_POLLS < 1) begin : g_bad_polls
    $error("MAX_POLLS must be at least 1");
  end

  logic [2:0] state;
  logic [2:0] next_state;
  logic [7:0] phase;
  logic       start_q;
  logic       armed;
  logic       start;
  logic       rs_l;
  logic       poll_l;
  logic       rs_sel;
  logic       poll_busy;
  logic       timeout_hit;
  logic       on_bus_next;
  logic       sample_now;

  // armed keeps a level held high across reset release from looking like a fresh edge.
  assign start       = iStart & ~start_q & armed;
  assign rs_sel      = (state == ST_IDLE && start) ? iRS : rs_l;
  assign poll_busy   = poll_l & ~rs_l & oDATA[7];
  assign sample_now  = (state == ST_EN_HIGH) && (phase == 8'(CLK_DIVIDE - 1));
  assign on_bus_next = (next_state == ST_SETUP) || (next_state == ST_EN_HIGH) ||
                       (next_state == ST_HOLD)  || (next_state == ST_CHECK);

`ifdef LCD_READ_TIMEOUT_EN
  localparam int PW = $clog2(MAX_POLLS + 1);
  logic [PW-1:0] poll_count;

  assign timeout_hit = poll_busy && (poll_count == PW'(MAX_POLLS));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      poll_count <= '0;
      oTimeout   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start)
        poll_count <= '0;
      else if (sample_now && poll_count != PW'(MAX_POLLS))
        poll_count <= poll_count + 1'b1;
      oTimeout <= (state == ST_CHECK) && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign oTimeout    = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_SETUP;
      ST_SETUP:   if (phase == 8'(SETUP_CYC - 1)) next_state = ST_EN_HIGH;
      ST_EN_HIGH: if (phase == 8'(CLK_DIVIDE - 1)) next_state = ST_HOLD;
      ST_HOLD:    if (phase == 8'(HOLD_CYC - 1)) next_state = ST_CHECK;
      ST_CHECK:   next_state = (poll_busy && !timeout_hit) ? ST_SETUP : ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from next_state so they line up with the state they belong to.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= ST_IDLE;
      phase     <= 8'd0;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      rs_l      <= 1'b0;
      poll_l    <= 1'b0;
      oDATA     <= 8'd0;
      oDone     <= 1'b0;
      oBUS_READ <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
    end else begin
      start_q <= iStart;
      if (!iStart)
        armed <= 1'b1;
      state <= next_state;
      if (next_state != state || state == ST_IDLE)
        phase <= 8'd0;
      else
        phase <= phase + 8'd1;
      if (state == ST_IDLE && start) begin
        rs_l   <= iRS;
        poll_l <= iPoll;
      end
      if (sample_now)
        oDATA <= LCD_DATA_IN;
      oDone     <= (next_state == ST_DONE);
      LCD_EN    <= (next_state == ST_EN_HIGH);
      LCD_RW    <= on_bus_next;
      oBUS_READ <= on_bus_next;
      LCD_RS    <= on_bus_next & rs_sel;
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: a transaction-level model predicts the byte, completion cycle
// and number of EN pulses; a monitor pops and compares whenever oDone fires.
module tb_lcd_bus_reader;

  localparam int S      = 2;
  localparam int D      = 16;
  localparam int H      = 2;
  localparam int MAXP   = 1024;
  localparam int FIRST  = S + D + H + 2;
  localparam int REPEAT = S + D + H + 1;

  typedef struct {
    logic [7:0] data;
    logic       timeout;
    int         done_cyc;
    int         reads;
    int         en_base;
  } exp_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [7:0] oDATA;
  logic       oDone;
  logic       oTimeout;
  logic       oBUS_READ;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  exp_t       sb[$];
  logic [7:0] bus_q[$];
  logic [7:0] script[$];
  logic [7:0] bus_last = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         en_pulses = 0;
  int         done_count = 0;
  int         last_c0 = 0;

  lcd_bus_reader #(
    .SETUP_CYC(S), .CLK_DIVIDE(D), .HOLD_CYC(H), .MAX_POLLS(MAXP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .oDATA(oDATA), .oDone(oDone), .oTimeout(oTimeout), .oBUS_READ(oBUS_READ),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc++;

  // The simulated LCD presents the next scripted byte for each read strobe, repeating the last one.
  always @(posedge LCD_EN) begin
    if (bus_q.size() > 0) bus_last = bus_q.pop_front();
    LCD_DATA_IN = bus_last;
    en_pulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reads continue while polling a status register that reports busy; the limit only exists with the macro.
  function automatic exp_t model(input logic rs, input logic poll, input logic [7:0] bytes[$],
                                 input int c0, input int en_base);
    exp_t       e;
    int         k;
    logic [7:0] b;
    k = 1;
    e.timeout = 1'b0;
    b = 8'h00;
    while (k < 100000) begin
      b = bytes[(k - 1 < bytes.size()) ? k - 1 : bytes.size() - 1];
      if (!(poll && !rs && b[7])) break;
`ifdef LCD_READ_TIMEOUT_EN
      if (k == MAXP) begin
        e.timeout = 1'b1;
        break;
      end
`endif
      k++;
    end
    e.data     = b;
    e.reads    = k;
    e.done_cyc = c0 + FIRST + (k - 1) * REPEAT;
    e.en_base  = en_base;
    return e;
  endfunction

  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (!iRST) begin
      if (oTimeout && !oDone) checkOutput("timeout_without_done", oTimeout, 1'b0);
      if (oDone) begin
        done_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", oDone, 1'b0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_data", oDATA, e.data);
          checkOutput("done_timeout", oTimeout, e.timeout);
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("en_pulse_count", en_pulses - e.en_base, e.reads);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rs, input logic poll, input bit leave_high, input bit expect_done);
    @(posedge iCLK); #1;
    iStart = 1'b0;
    @(posedge iCLK); #1;
    iRS   = rs;
    iPoll = poll;
    bus_q = script;
    iStart = 1'b1;
    last_c0 = cyc;
    if (expect_done) sb.push_back(model(rs, poll, script, cyc, en_pulses));
    if (!leave_high) begin
      @(posedge iCLK); #1;
      iStart = 1'b0;
    end
  endtask

  task automatic waitDone(input int bound);
    int n0;
    int i;
    n0 = done_count;
    i = 0;
    while (done_count == n0 && i < bound) begin
      @(negedge iCLK);
      i++;
    end
    @(negedge iCLK);
    checkOutput("done_within_bound", 32'(done_count != n0), 32'd1);
  endtask

  task automatic waitEnHigh(input int bound);
    int i;
    i = 0;
    do begin
      @(negedge iCLK);
      i++;
    end while (!LCD_EN && i < bound);
    checkOutput("en_seen_high", LCD_EN, 1'b1);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0;
    int en0;
    int nb;
    logic rs;
    logic poll;
    logic [7:0] tmp;

    iRST = 1'b1;
    @(negedge iCLK);
    checkOutput("reset_data", oDATA, 8'h00);
    checkOutput("reset_pins", {LCD_RW, LCD_EN, LCD_RS, oBUS_READ}, 4'b0000);
    checkOutput("reset_pulses", {oDone, oTimeout}, 2'b00);
    @(posedge iCLK); #1;
    iRST = 1'b0;

    // Data read with the EN window checked cycle by cycle.
    script.delete(); script.push_back(8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge iCLK);
      checkOutput($sformatf("en_cycle_%0d", cyc - last_c0), LCD_EN,
                  32'((cyc - last_c0) >= 3 && (cyc - last_c0) <= 18));
      if (k == 1 || k == 20) begin
        checkOutput("rs_rw_bus_during_read", {LCD_RS, LCD_RW, oBUS_READ}, 3'b111);
      end
    end
    waitDone(100);
    checkOutput("pins_idle_after_done", {LCD_RW, LCD_RS, oBUS_READ, LCD_EN}, 4'b0000);

    script.delete(); script.push_back(8'h85);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitDone(100);

    script.delete(); script.push_back(8'h80); script.push_back(8'h80); script.push_back(8'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitDone(200);

    for (int t = 0; t < 8; t++) begin
      rs   = 1'($urandom_range(0, 1));
      poll = 1'($urandom_range(0, 1));
      nb   = $urandom_range(0, 3);
      script.delete();
      for (int i = 0; i < nb; i++) begin
        tmp = 8'($urandom) | 8'h80;
        script.push_back(tmp);
      end
      tmp = 8'($urandom) & 8'h7F;
      script.push_back(tmp);
      applyStimulus(rs, poll, 1'b0, 1'b1);
      waitDone(300);
    end

    // Permanently busy display.
    script.delete(); script.push_back(8'hFF);
`ifdef LCD_READ_TIMEOUT_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitDone(MAXP * REPEAT + 100);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    n0  = done_count;
    en0 = en_pulses;
    repeat (1000) @(negedge iCLK);
    checkOutput("no_done_while_busy", done_count, n0);
    checkOutput("polling_continues", 32'((en_pulses - en0) >= 40), 32'd1);
`endif

    // Reset while EN is high, with iStart still held high.
    waitEnHigh(100);
    #2;
    iRST = 1'b1;
    #1;
    checkOutput("async_reset_pins", {LCD_EN, LCD_RW, oBUS_READ, LCD_RS}, 4'b0000);
    checkOutput("async_reset_data", oDATA, 8'h00);
    sb.delete();
    @(posedge iCLK); #1;
    iRST = 1'b0;
    en0 = en_pulses;
    n0  = done_count;
    repeat (40) @(negedge iCLK);
    checkOutput("no_restart_after_reset", en_pulses - en0, 0);
    checkOutput("bus_free_after_reset", oBUS_READ, 1'b0);
    checkOutput("no_done_after_reset", done_count, n0);
    script.delete(); script.push_back(8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitDone(100);

    // Level held through completion with a glitch during EN: one transaction only.
    script.delete(); script.push_back(8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitEnHigh(100);
    @(posedge iCLK); #1; iStart = 1'b0;
    @(posedge iCLK); #1; iStart = 1'b1;
    waitDone(100);
    n0 = done_count;
    repeat (40) @(negedge iCLK);
    checkOutput("single_done_for_held_start", done_count, n0);
    checkOutput("no_second_read_for_held_start", oBUS_READ, 1'b0);
    script.delete(); script.push_back(8'hC3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitDone(100);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side engine for the HD44780-compatible character LCD bus. It performs single read cycles (RW=1) to fetch either the busy-flag/address register or DDRAM/CGRAM data, and can optionally poll the busy flag until the LCD is ready. It sits beside the write controller on the shared LCD pins, with the LCD sequencer as its host. It uses the same start/done handshake the sequencer already uses for writes.

## Interface
Parameters:
- SETUP_CYC, default 2: cycles RS/RW are held stable before EN rises (address setup); valid range 1..255.
- CLK_DIVIDE, default 16: cycles LCD_EN is held high per read; valid range 1..255.
- HOLD_CYC, default 2: cycles RS/RW are held after EN falls; valid range 1..255.
- MAX_POLLS, default 1024: maximum reads per polled transaction. Used only when LCD_READ_TIMEOUT_EN is defined.

Ports:
- iCLK  in  1  system clock; the only clock.
- iRST  in  1  asynchronous, active-high reset.
- iStart  in  1  transaction request; a transaction starts on its rising edge.
- iRS  in  1  register select, latched at start: 0 = status (BF + address), 1 = data RAM.
- iPoll  in  1  latched at start; when 1 with iRS=0, repeat reads until bit7=0.
- oDATA  out  8  last byte sampled from the bus.
- oDone  out  1  one-cycle completion pulse.
- oTimeout  out  1  one-cycle pulse coincident with oDone when the poll limit is hit.
- oBUS_READ  out  1  high while a transaction owns the bus; top level tri-states its LCD_DATA drivers while this is high.
- LCD_DATA_IN  in  8  LCD data pins (input path).
- LCD_RW  out  1  LCD read/write.
- LCD_EN  out  1  LCD enable.
- LCD_RS  out  1  LCD register select.

## Operation
- Reset values: oDATA=0, oDone=0, oTimeout=0, oBUS_READ=0, LCD_RW=0, LCD_EN=0, LCD_RS=0, start-edge register=0, state=IDLE.
- Start detection:
  - iStart is registered every cycle.
  - start = iStart & ~iStart_q, and is honoured only in IDLE.
  - Edges arriving in any other state are ignored. A level held high through completion does not retrigger.
- States: IDLE → SETUP → EN_HIGH → HOLD → CHECK → DONE → IDLE.
  - IDLE: outputs low. On start, latch iRS/iPoll and go to SETUP.
  - SETUP: LCD_RW=1, LCD_RS=latched iRS, oBUS_READ=1, EN=0. Lasts SETUP_CYC cycles.
  - EN_HIGH: LCD_EN=1 for CLK_DIVIDE cycles. oDATA <= LCD_DATA_IN on the clock edge that ends the last EN_HIGH cycle.
  - HOLD: EN=0, RW/RS held. Lasts HOLD_CYC cycles.
  - CHECK: 1 cycle.
    - If polling is active (iPoll=1 and iRS=0) and oDATA[7]=1, increment the read count and return to SETUP.
    - Otherwise go to DONE.
    - iPoll is ignored when iRS=1.
  - DONE: oDone=1 for one cycle. LCD_RW, LCD_RS and oBUS_READ return to 0. Next state is IDLE.
- A single 8-bit phase counter times SETUP/EN_HIGH/HOLD and is cleared on every state change.
- oDATA holds its value between transactions.

## Timing
- Start edge seen in IDLE at cycle 0.
- SETUP occupies cycles 1..S, EN_HIGH S+1..S+D, HOLD S+D+1..S+D+H, CHECK S+D+H+1, DONE S+D+H+2.
- Defaults: EN high cycles 3..18; oDone at cycle 22.
- Each additional poll read adds S+D+H+1 = 21 cycles (defaults).
- Async reset at any point forces all outputs to their reset values immediately (LCD_EN drops without waiting for a clock). Nothing resumes after release until a new iStart rising edge.
- oDone and oTimeout are registered outputs, never combinational from inputs.

## Configuration
- LCD_READ_TIMEOUT_EN defined:
  - A poll counter of width $clog2(MAX_POLLS+1) counts reads in the transaction.
  - In CHECK, if BF=1 and count==MAX_POLLS, go to DONE with oTimeout=1 alongside oDone. oDATA keeps the last sample.
- LCD_READ_TIMEOUT_EN undefined:
  - Polling continues indefinitely.
  - oTimeout is tied to 0 and no counter is built.

## Test plan
- Data read, defaults: iRS=1, LCD_DATA_IN=8'h41, pulse iStart → LCD_RS=1/LCD_RW=1 from cycle 1, LCD_EN high cycles 3..18, oDATA=8'h41 and oDone high at cycle 22 only.
- Status read, no poll: iRS=0, iPoll=0, bus=8'h85 → exactly one EN pulse; oDATA=8'h85 and oDone at cycle 22 even though BF=1.
- Busy poll: iRS=0, iPoll=1, bus=8'h80 for the first two reads then 8'h05 → three EN pulses, oDone at cycle 64, oDATA=8'h05, oTimeout=0.
- Timeout: macro defined, MAX_POLLS=4, bus held 8'hFF, iPoll=1 → exactly 4 EN pulses, oDone=oTimeout=1 at cycle 85. Without the macro: no oDone within 1000 cycles and EN pulses continue.
- Reset mid-read: assert iRST at cycle 10 (EN high) → LCD_EN, LCD_RW and oBUS_READ are 0 before the next clock edge. After release with iStart held high, no transaction occurs until iStart goes low then high.
- Handshake: hold iStart high through completion and toggle it during EN_HIGH → exactly one transaction and one oDone. A later low→high edge in IDLE starts a second transaction.
